// File: rtl/argmax_topk_unit_if.sv
// Handshake and result bundle for argmax_topk_unit.
// master: the side that supplies score vectors and consumes results.
// slave : the selection unit itself.
interface argmax_topk_unit_if #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
);
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_CLASSES*DATA_W-1:0] scores;
  logic [DATA_W-1:0]             conf_threshold;
  logic                          out_valid;
  logic                          out_ready;
  logic [IDX_W-1:0]              best_idx;
  logic [DATA_W-1:0]             best_val;
  logic [IDX_W-1:0]              second_idx;
  logic [DATA_W-1:0]             second_val;
  logic [DATA_W-1:0]             margin;
  logic                          low_conf;
  logic                          busy;

  modport master (
    output in_valid, scores, conf_threshold, out_ready,
    input  in_ready, out_valid, best_idx, best_val, second_idx, second_val,
           margin, low_conf, busy
  );

  modport slave (
    input  in_valid, scores, conf_threshold, out_ready,
    output in_ready, out_valid, best_idx, best_val, second_idx, second_val,
           margin, low_conf, busy
  );
endinterface

// File: rtl/argmax_topk_unit.sv
// Sequential top-2 class selector. Captures a score vector, scans it LANES
// classes per cycle and holds best/second index+value, their margin and a
// low-confidence flag until the consumer accepts the result.
// Ties keep the lower index for both top-1 and top-2.
module argmax_topk_unit #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int SIGNED      = 0,
  parameter int LANES       = 1,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic              clk,
  input  logic              rst,
  argmax_topk_unit_if.slave bus
);

  // One extra bit so that "next index + LANES" never wraps.
  localparam int             CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] NUM_C = CNT_W'(NUM_CLASSES);
  localparam logic [CNT_W-1:0] STEP  = CNT_W'(LANES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] score_q [NUM_CLASSES];
  logic [DATA_W-1:0] score_d [NUM_CLASSES];
  logic [DATA_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [DATA_W-1:0] best_val_q, best_val_d;
  logic [IDX_W-1:0]  sec_idx_q, sec_idx_d;
  logic [DATA_W-1:0] sec_val_q, sec_val_d;
  logic              seen_q, seen_d;
  logic [IDX_W-1:0]  res_best_idx_q, res_best_idx_d;
  logic [DATA_W-1:0] res_best_val_q, res_best_val_d;
  logic [IDX_W-1:0]  res_sec_idx_q, res_sec_idx_d;
  logic [DATA_W-1:0] res_sec_val_q, res_sec_val_d;
  logic [DATA_W-1:0] res_margin_q, res_margin_d;
  logic              res_low_conf_q, res_low_conf_d;

  // Scan-chain temporaries
  logic [CNT_W-1:0]  k_s;
  logic [DATA_W-1:0] v_s;
  logic [IDX_W-1:0]  c_bi_s, c_si_s;
  logic [DATA_W-1:0] c_bv_s, c_sv_s;
  logic              c_seen_s;
  logic [DATA_W-1:0] margin_s;
  logic              low_conf_s;

  // Strict greater-than in the configured number format.
  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic r;
    if (SIGNED != 0) begin
      r = ($signed(a) > $signed(b));
    end else begin
      r = (a > b);
    end
    return r;
  endfunction

  // Status outputs decode the state register; in_ready is also gated by reset.
  assign bus.in_ready   = rst && (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.best_idx   = res_best_idx_q;
  assign bus.best_val   = res_best_val_q;
  assign bus.second_idx = res_sec_idx_q;
  assign bus.second_val = res_sec_val_q;
  assign bus.margin     = res_margin_q;
  assign bus.low_conf   = res_low_conf_q;

  // Lane chain: fold classes cnt_q .. cnt_q+LANES-1 into the running top-2.
  always_comb begin
    k_s      = '0;
    v_s      = '0;
    c_bi_s   = best_idx_q;
    c_bv_s   = best_val_q;
    c_si_s   = sec_idx_q;
    c_sv_s   = sec_val_q;
    c_seen_s = seen_q;
    for (int l = 0; l < LANES; l++) begin
      k_s = cnt_q + CNT_W'(l);
      if (k_s < NUM_C) begin
        v_s = score_q[k_s[IDX_W-1:0]];
        if (gt(v_s, c_bv_s)) begin
          c_si_s = c_bi_s;
          c_sv_s = c_bv_s;
          c_bi_s = k_s[IDX_W-1:0];
          c_bv_s = v_s;
        end else if (!c_seen_s || gt(v_s, c_sv_s)) begin
          c_si_s = k_s[IDX_W-1:0];
          c_sv_s = v_s;
        end else begin
          c_si_s = c_si_s;
        end
        c_seen_s = 1'b1;
      end else begin
        c_seen_s = c_seen_s;
      end
    end
    // best >= second always, so the DATA_W-bit difference is the exact margin.
    margin_s   = c_bv_s - c_sv_s;
    low_conf_s = (margin_s < thr_q);
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d        = state_q;
    score_d        = score_q;
    thr_d          = thr_q;
    cnt_d          = cnt_q;
    best_idx_d     = best_idx_q;
    best_val_d     = best_val_q;
    sec_idx_d      = sec_idx_q;
    sec_val_d      = sec_val_q;
    seen_d         = seen_q;
    res_best_idx_d = res_best_idx_q;
    res_best_val_d = res_best_val_q;
    res_sec_idx_d  = res_sec_idx_q;
    res_sec_val_d  = res_sec_val_q;
    res_margin_d   = res_margin_q;
    res_low_conf_d = res_low_conf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          for (int j = 0; j < NUM_CLASSES; j++) begin
            score_d[j] = bus.scores[j*DATA_W +: DATA_W];
          end
          thr_d      = bus.conf_threshold;
          best_idx_d = '0;
          best_val_d = bus.scores[DATA_W-1:0];
          sec_idx_d  = '0;
          sec_val_d  = '0;
          seen_d     = 1'b0;
          cnt_d      = CNT_W'(1);
          state_d    = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        best_idx_d = c_bi_s;
        best_val_d = c_bv_s;
        sec_idx_d  = c_si_s;
        sec_val_d  = c_sv_s;
        seen_d     = c_seen_s;
        cnt_d      = cnt_q + STEP;
        if ((cnt_q + STEP) >= NUM_C) begin
          res_best_idx_d = c_bi_s;
          res_best_val_d = c_bv_s;
          res_sec_idx_d  = c_si_s;
          res_sec_val_d  = c_sv_s;
          res_margin_d   = margin_s;
          res_low_conf_d = low_conf_s;
          state_d        = S_DONE;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any vector in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      for (int j = 0; j < NUM_CLASSES; j++) begin
        score_q[j] <= '0;
      end
      thr_q          <= '0;
      cnt_q          <= '0;
      best_idx_q     <= '0;
      best_val_q     <= '0;
      sec_idx_q      <= '0;
      sec_val_q      <= '0;
      seen_q         <= 1'b0;
      res_best_idx_q <= '0;
      res_best_val_q <= '0;
      res_sec_idx_q  <= '0;
      res_sec_val_q  <= '0;
      res_margin_q   <= '0;
      res_low_conf_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      score_q        <= score_d;
      thr_q          <= thr_d;
      cnt_q          <= cnt_d;
      best_idx_q     <= best_idx_d;
      best_val_q     <= best_val_d;
      sec_idx_q      <= sec_idx_d;
      sec_val_q      <= sec_val_d;
      seen_q         <= seen_d;
      res_best_idx_q <= res_best_idx_d;
      res_best_val_q <= res_best_val_d;
      res_sec_idx_q  <= res_sec_idx_d;
      res_sec_val_q  <= res_sec_val_d;
      res_margin_q   <= res_margin_d;
      res_low_conf_q <= res_low_conf_d;
    end
  end

endmodule

// File: tb/tb_argmax_topk_unit.sv
// Directed + randomized bench for argmax_topk_unit. Three instances run the
// same vectors: unsigned LANES=1, unsigned LANES=3, signed LANES=1.
module tb_argmax_topk_unit;

  localparam int N   = 10;
  localparam int W   = 16;
  localparam int SCW = N * W;
  localparam int RW  = 4 + W + 4 + W + W + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic [SCW-1:0] scores = '0;
  logic [W-1:0]   thr = '0;
  logic           out_ready = 1'b0;
  int             cyc = 0;
  int             n_cmp = 0;
  int             n_bad = 0;

  argmax_topk_unit_if #(.NUM_CLASSES(N), .DATA_W(W)) bu1 ();
  argmax_topk_unit_if #(.NUM_CLASSES(N), .DATA_W(W)) bu3 ();
  argmax_topk_unit_if #(.NUM_CLASSES(N), .DATA_W(W)) bs1 ();

  assign bu1.in_valid = in_valid;  assign bu1.scores = scores;
  assign bu1.conf_threshold = thr; assign bu1.out_ready = out_ready;
  assign bu3.in_valid = in_valid;  assign bu3.scores = scores;
  assign bu3.conf_threshold = thr; assign bu3.out_ready = out_ready;
  assign bs1.in_valid = in_valid;  assign bs1.scores = scores;
  assign bs1.conf_threshold = thr; assign bs1.out_ready = out_ready;

  argmax_topk_unit #(.NUM_CLASSES(N), .DATA_W(W), .SIGNED(0), .LANES(1)) u_u1 (
    .clk(clk), .rst(rst), .bus(bu1.slave));
  argmax_topk_unit #(.NUM_CLASSES(N), .DATA_W(W), .SIGNED(0), .LANES(3)) u_u3 (
    .clk(clk), .rst(rst), .bus(bu3.slave));
  argmax_topk_unit #(.NUM_CLASSES(N), .DATA_W(W), .SIGNED(1), .LANES(1)) u_s1 (
    .clk(clk), .rst(rst), .bus(bs1.slave));

  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack_res(input logic [3:0] bi, input logic [W-1:0] bv,
                                             input logic [3:0] si, input logic [W-1:0] sv,
                                             input logic [W-1:0] m, input logic lc);
    return {bi, bv, si, sv, m, lc};
  endfunction

  function automatic logic [RW-1:0] got_u1();
    return pack_res(bu1.best_idx, bu1.best_val, bu1.second_idx, bu1.second_val, bu1.margin, bu1.low_conf);
  endfunction
  function automatic logic [RW-1:0] got_u3();
    return pack_res(bu3.best_idx, bu3.best_val, bu3.second_idx, bu3.second_val, bu3.margin, bu3.low_conf);
  endfunction
  function automatic logic [RW-1:0] got_s1();
    return pack_res(bs1.best_idx, bs1.best_val, bs1.second_idx, bs1.second_val, bs1.margin, bs1.low_conf);
  endfunction

  function automatic bit gtm(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    if (sgn) return $signed(a) > $signed(b);
    else     return a > b;
  endfunction

  // Reference: top-1 = first maximum; top-2 = first maximum among the others.
  function automatic logic [RW-1:0] model(input logic [SCW-1:0] sc, input logic [W-1:0] th, input bit sgn);
    int b;
    int s;
    logic [W-1:0] bv, sv, m;
    b = 0;
    for (int k = 1; k < N; k++) if (gtm(sc[k*W +: W], sc[b*W +: W], sgn)) b = k;
    s = (b == 0) ? 1 : 0;
    for (int k = 0; k < N; k++) if (k != b && gtm(sc[k*W +: W], sc[s*W +: W], sgn)) s = k;
    bv = sc[b*W +: W];
    sv = sc[s*W +: W];
    m  = bv - sv;
    return pack_res(4'(b), bv, 4'(s), sv, m, (m < th));
  endfunction

  function automatic logic [SCW-1:0] pk(input logic [W-1:0] a [N]);
    logic [SCW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = a[k];
    return r;
  endfunction

  // Release all held results and confirm out_valid drops.
  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "/released"}, {61'd0, bu1.out_valid, bu3.out_valid, bs1.out_valid}, 64'd0);
  endtask

  // Present one vector, scramble inputs after accept, measure latency, check results.
  task automatic run_vec(input string tag, input logic [SCW-1:0] sc, input logic [W-1:0] th,
                         input logic [RW-1:0] exp_u, input logic [RW-1:0] exp_s, input bit hold);
    int  acc;
    int  lat [3];
    bit  ok;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (bu1.in_ready && bu3.in_ready && bs1.in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check_eq({tag, "/ready_timeout"}, 64'd0, 64'd1);
    scores = sc; thr = th; in_valid = 1'b1;
    @(negedge clk);
    acc = cyc; in_valid = 1'b0; scores = ~sc; thr = ~th;
    lat = '{-1, -1, -1};
    for (int t = 0; t < 40; t++) begin
      if (lat[0] < 0 && bu1.out_valid) lat[0] = cyc - acc;
      if (lat[1] < 0 && bu3.out_valid) lat[1] = cyc - acc;
      if (lat[2] < 0 && bs1.out_valid) lat[2] = cyc - acc;
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      @(negedge clk);
    end
    check_eq({tag, "/lat_u1"}, 64'(lat[0]), 64'd9);
    check_eq({tag, "/lat_u3"}, 64'(lat[1]), 64'd3);
    check_eq({tag, "/lat_s1"}, 64'(lat[2]), 64'd9);
    check_eq({tag, "/res_u1"}, 64'(got_u1()), 64'(exp_u));
    check_eq({tag, "/res_u3"}, 64'(got_u3()), 64'(exp_u));
    check_eq({tag, "/res_s1"}, 64'(got_s1()), 64'(exp_s));
    if (!hold) release_out(tag);
  endtask

  logic [W-1:0]   a [N];
  logic [W-1:0]   edge_tab [4];
  logic [SCW-1:0] v1, v3, v4, v5, vr;
  logic [RW-1:0]  e1, e3u, e3s, e4, e5u, e5s;
  logic [W-1:0]   thr_r;
  bit             ok_w;

  initial begin
    edge_tab = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
    a = '{16'd5, 16'd9, 16'd3, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    v1 = pk(a);
    e1 = pack_res(4'd1, 16'd9, 4'd3, 16'd9, 16'd0, 1'b1);
    a = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF};
    v3 = pk(a);
    e3u = pack_res(4'd7, 16'h8000, 4'd0, 16'h7FFF, 16'd1, 1'b0);
    e3s = pack_res(4'd0, 16'h7FFF, 4'd1, 16'h7FFF, 16'd0, 1'b1);
    a = '{16'hFFFD, 16'hFFFF, 16'hFFF9, 16'hFFFF, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE};
    v4 = pk(a);
    e4 = pack_res(4'd1, 16'hFFFF, 4'd3, 16'hFFFF, 16'd0, 1'b0);
    a = '{16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    v5 = pk(a);
    e5u = pack_res(4'd0, 16'h8000, 4'd2, 16'h8000, 16'd0, 1'b1);
    e5s = pack_res(4'd1, 16'h7FFF, 4'd0, 16'h8000, 16'hFFFF, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("reset/res_u1", 64'(got_u1()), 64'd0);
    check_eq("reset/res_s1", 64'(got_s1()), 64'd0);
    check_eq("reset/flags_u1", {61'd0, bu1.in_ready, bu1.out_valid, bu1.busy}, 64'd4);
    check_eq("reset/flags_u3", {61'd0, bu3.in_ready, bu3.out_valid, bu3.busy}, 64'd4);

    // Ties keep lower index; then hold under backpressure
    run_vec("tie", v1, 16'd1, e1, e1, 1'b1);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      check_eq("hold_u1", 64'({bu1.in_ready, bu1.out_valid, got_u1()}), 64'({1'b0, 1'b1, e1}));
    end
    // Release with a new vector already offered: must not be accepted in the same cycle
    scores = v4; thr = 16'd0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("handoff/after_release", {61'd0, bu1.in_ready, bu1.out_valid, bu1.busy}, 64'd4);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("handoff/accepted_next", {63'd0, bu1.busy}, 64'd1);
    ok_w = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (bu1.out_valid && bs1.out_valid) begin ok_w = 1'b1; break; end
      @(negedge clk);
    end
    check_eq("handoff/done", {63'd0, ok_w}, 64'd1);
    check_eq("handoff/res_u1", 64'(got_u1()), 64'(e4));
    check_eq("handoff/res_s1", 64'(got_s1()), 64'(e4));
    release_out("handoff");

    run_vec("msb", v3, 16'd1, e3u, e3s, 1'b0);
    run_vec("neg", v4, 16'd0, e4, e4, 1'b0);
    run_vec("wide", v5, 16'hFFFF, e5u, e5s, 1'b0);

    // Reset in the middle of a scan
    scores = v5; thr = 16'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst/u1", {62'd0, bu1.out_valid, bu1.busy}, 64'd0);
    check_eq("midrst/u3", {62'd0, bu3.out_valid, bu3.busy}, 64'd0);
    check_eq("midrst/res_s1", 64'(got_s1()), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst/ready", {61'd0, bu1.in_ready, bu3.in_ready, bs1.in_ready}, 64'd7);
    run_vec("post_rst", v1, 16'd1, e1, e1, 1'b0);

    // Random vectors with frequent ties and edge values
    for (int r = 0; r < 200; r++) begin
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 2))
          0:       vr[k*W +: W] = 16'($urandom);
          1:       vr[k*W +: W] = 16'($urandom_range(0, 3));
          default: vr[k*W +: W] = edge_tab[$urandom_range(0, 3)];
        endcase
      end
      thr_r = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 4)) : 16'($urandom);
      run_vec("rand", vr, thr_r, model(vr, thr_r, 1'b0), model(vr, thr_r, 1'b1), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/argmax_topk_unit.md
Name: argmax_topk_unit

Overview:
- Parametrised sequential class-selection unit placed after the softmax or final dense layer of the inference pipeline.
- Captures a flat score vector via a valid/ready handshake and scans it LANES classes per cycle.
- Returns the top-1 and top-2 indices and values, their margin, and a low-confidence flag.
- Generalises the inline one-shot argmax: width, class count, signedness and scan parallelism are configurable, tie-breaking is defined, and results are held under output backpressure.

Parameters:
- NUM_CLASSES, 10, number of scores; must be >= 2.
- DATA_W, 16, bits per score.
- SIGNED, 0, 0 = unsigned compare (softmax probabilities), 1 = two's-complement compare (raw logits).
- LANES, 1, classes compared per scan cycle, 1..NUM_CLASSES-1.
- IDX_W, $clog2(NUM_CLASSES), index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  score vector valid.
- in_ready  out  1  unit can accept a vector.
- scores  in  NUM_CLASSES*DATA_W  class k at bits [k*DATA_W +: DATA_W].
- conf_threshold  in  DATA_W  unsigned margin threshold; sampled at accept.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- best_idx  out  IDX_W  top-1 class index.
- best_val  out  DATA_W  top-1 score.
- second_idx  out  IDX_W  top-2 class index.
- second_val  out  DATA_W  top-2 score.
- margin  out  DATA_W  best_val - second_val as an unsigned difference.
- low_conf  out  1  margin < conf_threshold.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All registered outputs and internal registers clear to 0; out_valid=0.
  - in_ready=1 while rst is deasserted and the state is IDLE.
  - Reset during SCAN or DONE aborts the vector and discards the pending result.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid is high, the vector is accepted: capture scores and conf_threshold into internal registers, set best=(0, score0), second_seen=0, next index i=1, go to SCAN.
  - SCAN: in_ready=0. Each cycle processes classes i..min(i+LANES,NUM_CLASSES)-1 in ascending order as a combinational chain. i advances by LANES. The cycle that processes index NUM_CLASSES-1 registers the final results and enters DONE.
  - DONE: out_valid=1 and outputs are stable. When out_ready is high, go to IDLE with out_valid=0. The next vector can be accepted in the following cycle, not the same one.
- Update rule per class v at index i:
  - If v > best_val: second := best; best := (i, v).
  - Else if !second_seen or v > second_val: second := (i, v).
  - Then second_seen := 1.
- Comparison is strict, so ties keep the lower index. This applies to both top-1 and top-2.
- Compare is signed when SIGNED=1, unsigned otherwise.
- margin is best_val - second_val and is never negative. It is computed at DATA_W+1 bits and stored as the low DATA_W bits, which is exact for both modes.
- low_conf is an unsigned compare of margin against the captured threshold.
- Latency: SCAN lasts ceil((NUM_CLASSES-1)/LANES) cycles. out_valid rises on the edge that ends the last SCAN cycle.
  - NUM_CLASSES=10, LANES=1: 9 cycles after the accept edge.
  - NUM_CLASSES=10, LANES=3: 3 cycles after the accept edge.
- Changes to scores, in_valid or conf_threshold outside the accept cycle have no effect.
- out_ready while out_valid=0 is ignored.
- Outputs are registered only; no combinational path from inputs to result outputs.
- Results are identical for every legal LANES value.

Test Plan:
- Unsigned, N=10, LANES=1, scores [5,9,3,9,0,0,0,0,0,0], threshold 1 -> best_idx=1, best_val=9, second_idx=3, second_val=9, margin=0, low_conf=1; out_valid 9 cycles after accept.
- Unsigned, score7=0x8000 and all others 0x7FFF -> best_idx=7, second_idx=0, margin=1. Repeat with SIGNED=1 -> 0x8000 loses; best_idx=0, second_idx=1.
- SIGNED=1, scores [-3,-1,-7,-1,-2,...,-2] -> best_idx=1 (val -1), second_idx=3 (val -1), margin=0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> outputs stable and in_ready=0 throughout. Pulse out_ready -> out_valid=0 next cycle. A new vector is accepted the cycle after that.
- LANES=3 vs LANES=1 on 200 random vectors -> identical results; per-vector latency 3 vs 9 cycles.
- Assert rst=0 mid-SCAN -> out_valid=0 and busy=0 immediately. After release, in_ready=1 and the next vector produces a correct result.
